// File: rtl/regfile_mp_pkg.sv
// pcpu: shared register-file types and sizes for the pcpu pipeline
package pcpu;
    localparam int REG_XLEN = 32;
    localparam int REG_NUM  = 32;

    typedef logic [4:0] reg_addr_t;

    typedef struct packed {
        logic [31:0] x0,  x1,  x2,  x3,  x4,  x5,  x6,  x7;
        logic [31:0] x8,  x9,  x10, x11, x12, x13, x14, x15;
        logic [31:0] x16, x17, x18, x19, x20, x21, x22, x23;
        logic [31:0] x24, x25, x26, x27, x28, x29, x30, x31;
    } RV32_Regs_t;
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, write and scoreboard bus of the multi-port register file
interface regfile_mp_if #(
    parameter int XLEN  = pcpu::REG_XLEN,
    parameter int NREGS = pcpu::REG_NUM,
    parameter int NRD   = 2,
    parameter int NWR   = 1
);
    localparam int AW = $clog2(NREGS);
    logic [NRD-1:0][AW-1:0]   rd_addr;
    logic [NRD-1:0][XLEN-1:0] rd_data;
    logic [NRD-1:0]           rd_busy;
    logic [NWR-1:0]           wr_en;
    logic [NWR-1:0][AW-1:0]   wr_addr;
    logic [NWR-1:0][XLEN-1:0] wr_data;
    logic                     sb_set;
    logic [AW-1:0]            sb_addr;
    logic [NREGS-1:0]         sb_busy;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr,
        input  rd_data, rd_busy, sb_busy
    );
    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr,
        output rd_data, rd_busy, sb_busy
    );
endinterface

// File: rtl/regfile_mp_scoreboard.sv
// regfile_scoreboard: per-register pending-write bits; a same-cycle set beats a clear
module regfile_scoreboard import pcpu::*; #(
    parameter int NREGS = REG_NUM,
    parameter int NWR   = 1,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sb_set,
    input  logic [AW-1:0]          sb_addr,
    input  logic [NWR-1:0]         wr_en,
    input  logic [NWR-1:0][AW-1:0] wr_addr,
    output logic [NREGS-1:0]       sb_busy
);
    logic [NREGS-1:0] r_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            for (int i = 0; i < NWR; i++)
                if (wr_en[i]) r_busy[wr_addr[i]] <= 1'b0;
            if (sb_set && sb_addr != '0) r_busy[sb_addr] <= 1'b1;
            r_busy[0] <= 1'b0;
        end
    end

    assign sb_busy = r_busy;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file, negedge reads with write bypass, x0 hard zero
// Define REGFILE_VGA_EN to add the regs_for_vga snapshot port (XLEN==32, NREGS==32 only).
module regfile_mp import pcpu::*; #(
    parameter int XLEN  = REG_XLEN,
    parameter int NREGS = REG_NUM,
    parameter int NRD   = 2,
    parameter int NWR   = 1
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef REGFILE_VGA_EN
    output RV32_Regs_t   regs_for_vga,
`endif
    regfile_mp_if.slave  bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]          r_regs [NREGS];
    logic [NRD-1:0][XLEN-1:0] r_rd_data, w_rd_data;
    logic [NRD-1:0]           r_rd_busy, w_rd_busy;
    logic [NREGS-1:0]         w_sb_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NREGS; k++) r_regs[k] <= '0;
        end else begin
            for (int i = 0; i < NWR; i++)
                if (bus.wr_en[i] && bus.wr_addr[i] != '0) r_regs[bus.wr_addr[i]] <= bus.wr_data[i];
        end
    end

    // Later write ports are younger, so the last match in the loop wins the bypass.
    always_comb begin
        w_rd_data = '0;
        w_rd_busy = '0;
        for (int j = 0; j < NRD; j++) begin
            w_rd_data[j] = r_regs[bus.rd_addr[j]];
            w_rd_busy[j] = w_sb_busy[bus.rd_addr[j]];
            for (int i = 0; i < NWR; i++)
                if (bus.wr_en[i] && bus.wr_addr[i] == bus.rd_addr[j]) begin
                    w_rd_data[j] = bus.wr_data[i];
                    w_rd_busy[j] = 1'b0;
                end
            if (bus.rd_addr[j] == '0) begin
                w_rd_data[j] = '0;
                w_rd_busy[j] = 1'b0;
            end
        end
    end

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            r_rd_data <= '0;
            r_rd_busy <= '0;
        end else begin
            r_rd_data <= w_rd_data;
            r_rd_busy <= w_rd_busy;
        end
    end

    regfile_scoreboard #(.NREGS(NREGS), .NWR(NWR), .AW(AW)) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .sb_set  (bus.sb_set),
        .sb_addr (bus.sb_addr),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .sb_busy (w_sb_busy)
    );

    assign bus.rd_data = r_rd_data;
    assign bus.rd_busy = r_rd_busy;
    assign bus.sb_busy = w_sb_busy;

`ifdef REGFILE_VGA_EN
    if (XLEN != 32 || NREGS != 32) begin : g_vga_bad
        $fatal(1, "regs_for_vga needs XLEN==32 and NREGS==32");
    end
    // x0 is the most significant field of the packed snapshot.
    logic [31:0][31:0] w_vga;
    always_comb begin
        w_vga = '0;
        for (int k = 1; k < 32; k++) w_vga[31-k] = r_regs[k];
    end
    assign regs_for_vga = RV32_Regs_t'(w_vga);
`endif
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized scoreboard bench for regfile_mp against an array model
module tb_regfile_mp;
    import pcpu::*;
    localparam int XLEN = 32, NREGS = 32, NRD = 2, NWR = 2, AW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();
`ifdef REGFILE_VGA_EN
    RV32_Regs_t vga;
`endif

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef REGFILE_VGA_EN
        .regs_for_vga (vga),
`endif
        .bus          (bus.master)
    );

    typedef struct {
        logic [NRD-1:0][XLEN-1:0] d;
        logic [NRD-1:0]           b;
        logic [NREGS-1:0]         sb;
        string                    tag;
    } exp_t;

    exp_t             q[$];
    logic [XLEN-1:0]  m_regs [NREGS];
    logic [NREGS-1:0] m_busy;
    int checks = 0;
    int errors = 0;

    // Expectations come from the pre-edge model; the model then advances to the next posedge.
    task automatic step(input logic rst, input logic [NWR-1:0] we,
                        input logic [NWR-1:0][AW-1:0] wa, input logic [NWR-1:0][XLEN-1:0] wd,
                        input logic [NRD-1:0][AW-1:0] ra, input logic ss,
                        input logic [AW-1:0] sa, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst;
        bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
        bus.rd_addr = ra; bus.sb_set = ss; bus.sb_addr = sa;
        e.sb = m_busy;
        e.tag = tag;
        for (int j = 0; j < NRD; j++) begin
            e.d[j] = m_regs[ra[j]];
            e.b[j] = m_busy[ra[j]];
            for (int i = 0; i < NWR; i++)
                if (we[i] && wa[i] == ra[j]) begin
                    e.d[j] = wd[i];
                    e.b[j] = 1'b0;
                end
            if (ra[j] == 0 || !rst) begin
                e.d[j] = '0;
                e.b[j] = 1'b0;
            end
        end
        q.push_back(e);
        if (!rst) begin
            for (int k = 0; k < NREGS; k++) m_regs[k] = '0;
            m_busy = '0;
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (we[i] && wa[i] != 0) m_regs[wa[i]] = wd[i];
                if (we[i]) m_busy[wa[i]] = 1'b0;
            end
            if (ss && sa != 0) m_busy[sa] = 1'b1;
        end
    endtask

    task automatic idle_read(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input string tag);
        step(1'b1, 2'b00, '0, '0, {a1, a0}, 1'b0, '0, tag);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                for (int j = 0; j < NRD; j++) begin
                    checks++;
                    if (bus.rd_data[j] !== e.d[j]) begin
                        errors++;
                        $display("FAIL %s rd_data[%0d] got %h expected %h", e.tag, j, bus.rd_data[j], e.d[j]);
                    end
                    checks++;
                    if (bus.rd_busy[j] !== e.b[j]) begin
                        errors++;
                        $display("FAIL %s rd_busy[%0d] got %b expected %b", e.tag, j, bus.rd_busy[j], e.b[j]);
                    end
                end
                checks++;
                if (bus.sb_busy !== e.sb) begin
                    errors++;
                    $display("FAIL %s sb_busy got %h expected %h", e.tag, bus.sb_busy, e.sb);
                end
            end
        end
    end

    initial begin
        logic [NWR-1:0][AW-1:0]   wa;
        logic [NWR-1:0][XLEN-1:0] wd;
        logic [NRD-1:0][AW-1:0]   ra;
        for (int k = 0; k < NREGS; k++) m_regs[k] = '0;
        m_busy = '0;
        bus.wr_en = '0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_addr = '0; bus.sb_set = 1'b0; bus.sb_addr = '0;
        repeat (3) @(posedge clk);

        for (int n = 0; n < 6; n++) begin
            wa[0] = AW'($urandom_range(1, 31)); wa[1] = AW'($urandom_range(1, 31));
            wd[0] = $urandom; wd[1] = $urandom;
            step(1'b1, 2'b11, wa, wd, {wa[1], wa[0]}, 1'b1, wa[0], "prefill");
        end
        step(1'b0, 2'b11, {5'd6, 5'd2}, {32'h11, 32'h22}, {5'd6, 5'd2}, 1'b1, 5'd2, "reset0");
        step(1'b0, 2'b00, '0, '0, {5'd6, 5'd2}, 1'b0, '0, "reset1");
`ifdef REGFILE_VGA_EN
        @(negedge clk);
        #2;
        checks++;
        if (vga !== '0) begin
            errors++;
            $display("FAIL vga_reset got %h expected 0", vga);
        end
`endif
        idle_read(5'd6, 5'd2, "after_reset");

        step(1'b1, 2'b01, {5'd0, 5'd5}, {32'd0, 32'hDEADBEEF}, '0, 1'b0, '0, "wr_x5");
        idle_read(5'd5, 5'd0, "rd_x5");
        step(1'b1, 2'b01, {5'd0, 5'd0}, {32'd0, 32'h1234}, {5'd0, 5'd0}, 1'b0, '0, "wr_x0");
        idle_read(5'd0, 5'd5, "rd_x0");

        step(1'b1, 2'b01, {5'd0, 5'd7}, {32'd0, 32'hA5A5A5A5}, {5'd7, 5'd5}, 1'b0, '0, "bypass_x7");
        step(1'b1, 2'b11, {5'd9, 5'd9}, {32'h2, 32'h1}, {5'd9, 5'd9}, 1'b0, '0, "dual_wr_x9");
        idle_read(5'd9, 5'd7, "rd_x9");

        step(1'b1, 2'b00, '0, '0, {5'd3, 5'd3}, 1'b1, 5'd3, "sb_set_x3");
        idle_read(5'd3, 5'd0, "busy_x3");
        step(1'b1, 2'b01, {5'd0, 5'd3}, {32'd0, 32'h33}, {5'd3, 5'd3}, 1'b0, '0, "clr_x3");
        idle_read(5'd3, 5'd0, "idle_x3");
        step(1'b1, 2'b10, {5'd3, 5'd0}, {32'h44, 32'd0}, {5'd3, 5'd0}, 1'b1, 5'd3, "set_clr_x3");
        idle_read(5'd3, 5'd0, "set_wins_x3");
        step(1'b1, 2'b00, '0, '0, '0, 1'b1, 5'd0, "sb_set_x0");
        idle_read(5'd0, 5'd3, "busy_x0");

        step(1'b1, 2'b01, {5'd0, 5'd4}, {32'd0, 32'h77}, '0, 1'b1, 5'd4, "pre_x4");
        step(1'b0, 2'b01, {5'd0, 5'd4}, {32'd0, 32'hFF}, {5'd4, 5'd4}, 1'b1, 5'd4, "rst_wr_x4");
        idle_read(5'd4, 5'd3, "rd_x4");
        idle_read(5'd4, 5'd9, "rd_x4_again");

        for (int n = 0; n < 400; n++) begin
            int lim;
            lim = (n % 3 == 0) ? 31 : 7;
            wa[0] = AW'($urandom_range(0, lim)); wa[1] = AW'($urandom_range(0, lim));
            ra[0] = AW'($urandom_range(0, lim)); ra[1] = AW'($urandom_range(0, lim));
            wd[0] = $urandom; wd[1] = $urandom;
            step($urandom_range(0, 49) != 0, NWR'($urandom), wa, wd, ra,
                 1'($urandom), AW'($urandom_range(0, lim)), "random");
        end
        idle_read(5'd1, 5'd2, "tail");

        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
